piso_tx_ctrl: RTL and testbench
===============================

Name: piso_tx_ctrl

Overview:
Sequencer for a 4-bit-class parallel-in/serial-out shift register. It accepts parallel words through a valid/ready handshake and buffers one pending word. It drives the load and shift of the serializer and emits a framed serial bit stream with per-bit valid and last markers. It sits between a word producer and any single-wire serial consumer.

Parameters:
WIDTH, 4, bits per word (>=2)
MSB_FIRST, 1, 1 = in_data[WIDTH-1] transmitted first; 0 = in_data[0] first
GAP, 1, idle cycles forced between consecutive words (0..15; 0 = back-to-back)

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
in_data  input  WIDTH  parallel word
in_valid  input  1  producer offers in_data
in_ready  output  1  controller can accept; a transfer occurs on an edge where in_valid && in_ready
ser_out  output  1  serial data bit; forced 0 when ser_valid=0
ser_valid  output  1  ser_out carries a data bit this cycle
ser_last  output  1  current bit is the final bit of its word
busy  output  1  shifting or gap in progress, or hold register full

Behaviour:
- Reset (async, active-high, immediate): state=IDLE, hold empty, shifter=0, bit counter=0, gap counter=0. Outputs: ser_out=0, ser_valid=0, ser_last=0, busy=0, in_ready=0 while rst=1 and 1 after release. Any word in flight or in hold is discarded. No partial bits are emitted after release.
- Hold register: one entry. in_ready = !hold_full. On an accept edge, hold captures in_data and hold_full becomes 1. There is no same-cycle accept-while-transfer path.
- FSM states: IDLE, SHIFT, GAP.
  - IDLE: if hold_full at the edge, load the shifter from hold, clear hold_full, set bit counter=WIDTH-1, and go to SHIFT. Otherwise stay in IDLE.
  - SHIFT: ser_valid=1 and ser_out=current output bit (MSB or LSB per MSB_FIRST). Each edge shifts by one and decrements the counter. ser_last=1 when counter==0.
  - Exit from the last bit's edge: if GAP>0, go to GAP with gap counter=GAP-1. If GAP==0 and hold_full, reload immediately and stay in SHIFT (no bubble). If GAP==0 and hold empty, go to IDLE.
  - GAP: ser_valid=0. Count down; at 0 go to IDLE. The hold register may still accept during GAP.
- Latency: a word accepted at edge E0 (into an empty system) is loaded at E1. Its first bit is valid between E1 and E2. The last bit is valid between E(WIDTH) and E(WIDTH+1).
- Throughput: one word per WIDTH+GAP cycles at steady state, plus one IDLE cycle when GAP>0 (the load happens from IDLE).
- The hold word stays stable while in_ready=0. The producer must hold in_data/in_valid until accepted; the controller never drops an accepted word except on reset.
- busy = (state!=IDLE) || hold_full.
- The shifter fills with 0 on shift.
- All outputs are registered or decoded from registered state only; there is no combinational path from in_valid to ser_*.

Decomposition:
- Shared package/include piso_ctrl_pkg: state encodings (ST_IDLE=2'd0, ST_SHIFT=2'd1, ST_GAP=2'd2) and the counter width localparam CNT_W=$clog2(WIDTH).
- Sub-module piso_shreg (WIDTH, MSB_FIRST): load/shift enable, async active-high rst, serial output bit. piso_tx_ctrl contains the FSM, hold register and counters.

Test Plan:
- Reset: assert rst=1 mid-cycle -> ser_out=0, ser_valid=0, busy=0 immediately; in_ready=1 after release.
- Single word, WIDTH=4, MSB_FIRST=1, GAP=1: accept 4'b1001 at E0 -> ser_out 1,0,0,1 with ser_valid=1 in cycles E1..E4, ser_last=1 only in the 4th bit, busy=0 from E6.
- Back-to-back, GAP=1: 4'b1001 then 4'b0110 held valid -> second word accepted at E2; stream 1,0,0,1, gap (ser_valid=0), idle, 0,1,1,0. With GAP=0 the stream is 1,0,0,1,0,1,1,0 with no bubble.
- Backpressure: offer a third word while hold is full -> in_ready=0 until hold transfers; the third word is accepted afterwards and emitted intact, with no loss or duplication.
- Reset mid-shift: assert rst after 2 bits of 4'b1011 -> outputs go to 0 at once; after release, no remaining bits appear and a new word 4'b0001 is emitted cleanly.
- LSB-first: MSB_FIRST=0, word 4'b1101 -> ser_out 1,0,1,1.

Source files
------------

// File: rtl/piso_ctrl_pkg.sv
// piso_ctrl_pkg
// Shared definitions for the parallel-in/serial-out transmit controller:
//   - state_t   : FSM state encodings (IDLE / SHIFT / GAP)
//   - CNT_W     : bit-counter width for the default 4-bit word
//   - GAP_W     : gap-counter width (GAP ranges 0..15)
//   - cnt_width : bit-counter width for an arbitrary word width
package piso_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 4;
  localparam int CNT_W     = $clog2(DEF_WIDTH);
  localparam int GAP_W     = 4;

  // Counter width needed to count WIDTH-1 down to 0. A 2-bit word still
  // needs one counter bit, so never return less than 1.
  function automatic int cnt_width(input int width);
    if (width <= 2) begin
      return 1;
    end
    return $clog2(width);
  endfunction

endpackage

// File: rtl/piso_shreg.sv
// piso_shreg
// Parallel-load shift register that presents one serial bit.
// Ports:
//   clk   : rising-edge clock
//   rst   : asynchronous active-high reset, clears the register
//   load  : capture din (wins over shift)
//   shift : move one position toward the output end, filling with 0
//   din   : parallel word
//   sout  : current output bit (MSB when MSB_FIRST!=0, else LSB)
module piso_shreg
  import piso_ctrl_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] din,
  output logic             sout
);

  logic [WIDTH-1:0] sh;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh <= '0;
    end else if (load) begin
      sh <= din;
    end else if (shift) begin
      if (MSB_FIRST != 0) begin
        sh <= {sh[WIDTH-2:0], 1'b0};
      end else begin
        sh <= {1'b0, sh[WIDTH-1:1]};
      end
    end
  end

  assign sout = (MSB_FIRST != 0) ? sh[WIDTH-1] : sh[0];

endmodule

// File: rtl/piso_tx_ctrl.sv
// piso_tx_ctrl
// Sequencer for a parallel-in/serial-out transmitter. Words arrive through a
// valid/ready handshake into a one-entry hold register, are loaded into the
// serializer, and leave as a framed bit stream with per-bit valid and last.
// Ports:
//   clk       : rising-edge clock
//   rst       : asynchronous active-high reset
//   in_data   : parallel word from the producer
//   in_valid  : producer offers in_data
//   in_ready  : controller can accept (hold register empty, not in reset)
//   ser_out   : serial data bit, 0 whenever ser_valid is 0
//   ser_valid : ser_out carries a data bit this cycle
//   ser_last  : current bit is the final bit of its word
//   busy      : shifting, gapping, or hold register occupied
//   dbg_state : current FSM state (state_t encoding)
//
// Handshake: a word transfers on every rising edge where in_valid && in_ready.
// The producer keeps in_data/in_valid stable until that edge; in_ready depends
// only on registered state (and rst), never on in_valid.
module piso_tx_ctrl
  import piso_ctrl_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int MSB_FIRST = 1,
  parameter int GAP       = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             ser_last,
  output logic             busy,
  output logic [1:0]       dbg_state
);

  localparam int                 CW        = cnt_width(WIDTH);
  localparam logic [CW-1:0]      CNT_INIT  = CW'(WIDTH - 1);
  localparam bit                 HAS_GAP   = (GAP > 0);
  localparam logic [GAP_W-1:0]   GAP_INIT  = (GAP > 0) ? GAP_W'(GAP - 1) : '0;

  state_t            state;
  logic              hold_full;
  logic [WIDTH-1:0]  hold_q;
  logic [CW-1:0]     bit_cnt;
  logic [GAP_W-1:0]  gap_cnt;

  logic              accept;
  logic              load;
  logic              shift;
  logic              sh_bit;
  logic              last_bit;

  assign in_ready = !hold_full && !rst;
  assign accept   = in_valid && in_ready;
  assign last_bit = (bit_cnt == '0);

  // Serializer control. With no gap, the last bit's edge reloads straight
  // from hold so back-to-back words have no bubble; otherwise every load
  // happens from IDLE.
  always_comb begin
    load  = 1'b0;
    shift = 1'b0;
    case (state)
      ST_IDLE: begin
        load = hold_full;
      end
      ST_SHIFT: begin
        if (last_bit && !HAS_GAP && hold_full) begin
          load = 1'b1;
        end else begin
          shift = 1'b1;
        end
      end
      default: begin
        load  = 1'b0;
        shift = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      hold_full <= 1'b0;
      hold_q    <= '0;
      bit_cnt   <= '0;
      gap_cnt   <= '0;
    end else begin
      // Accept requires an empty hold and load requires a full one, so the
      // two never coincide on the same edge.
      if (accept) begin
        hold_q    <= in_data;
        hold_full <= 1'b1;
      end else if (load) begin
        hold_full <= 1'b0;
      end

      case (state)
        ST_IDLE: begin
          if (hold_full) begin
            state   <= ST_SHIFT;
            bit_cnt <= CNT_INIT;
          end
        end
        ST_SHIFT: begin
          if (last_bit) begin
            if (HAS_GAP) begin
              state   <= ST_GAP;
              gap_cnt <= GAP_INIT;
            end else if (hold_full) begin
              bit_cnt <= CNT_INIT;
            end else begin
              state <= ST_IDLE;
            end
          end else begin
            bit_cnt <= bit_cnt - 1'b1;
          end
        end
        ST_GAP: begin
          if (gap_cnt == '0) begin
            state <= ST_IDLE;
          end else begin
            gap_cnt <= gap_cnt - 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  piso_shreg #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_shreg (
    .clk   (clk),
    .rst   (rst),
    .load  (load),
    .shift (shift),
    .din   (hold_q),
    .sout  (sh_bit)
  );

  // All serial outputs decode from registered state only.
  assign ser_valid = (state == ST_SHIFT);
  assign ser_out   = ser_valid && sh_bit;
  assign ser_last  = ser_valid && last_bit;
  assign busy      = (state != ST_IDLE) || hold_full;
  assign dbg_state = state;

endmodule

// File: tb/tb_piso_tx_ctrl.sv
// tb_piso_tx_ctrl
// Directed bench for piso_tx_ctrl. Three instances share clk/rst:
//   index 0 : MSB first, GAP=1
//   index 1 : MSB first, GAP=0
//   index 2 : LSB first, GAP=1
// Per-cycle expected entries are {in_ready, busy, ser_valid, ser_out, ser_last}.
module tb_piso_tx_ctrl;

  logic       clk;
  logic       rst;
  logic [3:0] din [3];
  logic       dv  [3];
  logic       rdy [3];
  logic       so  [3];
  logic       sv  [3];
  logic       sl  [3];
  logic       bsy [3];
  logic [1:0] st  [3];

  int n_checks = 0;
  int n_fails  = 0;

  logic [4:0] exp_q[$];

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  piso_tx_ctrl #(.WIDTH(4), .MSB_FIRST(1), .GAP(1)) u_dut_a (
    .clk(clk), .rst(rst), .in_data(din[0]), .in_valid(dv[0]), .in_ready(rdy[0]),
    .ser_out(so[0]), .ser_valid(sv[0]), .ser_last(sl[0]), .busy(bsy[0]),
    .dbg_state(st[0])
  );

  piso_tx_ctrl #(.WIDTH(4), .MSB_FIRST(1), .GAP(0)) u_dut_b (
    .clk(clk), .rst(rst), .in_data(din[1]), .in_valid(dv[1]), .in_ready(rdy[1]),
    .ser_out(so[1]), .ser_valid(sv[1]), .ser_last(sl[1]), .busy(bsy[1]),
    .dbg_state(st[1])
  );

  piso_tx_ctrl #(.WIDTH(4), .MSB_FIRST(0), .GAP(1)) u_dut_c (
    .clk(clk), .rst(rst), .in_data(din[2]), .in_valid(dv[2]), .in_ready(rdy[2]),
    .ser_out(so[2]), .ser_valid(sv[2]), .ser_last(sl[2]), .busy(bsy[2]),
    .dbg_state(st[2])
  );

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver ----------------
  // Offer one word and hold it until the edge that transfers it.
  task automatic send(input int d, input logic [3:0] w);
    int   waited;
    logic r;
    din[d] = w;
    dv[d]  = 1'b1;
    waited = 0;
    r      = 1'b0;
    do begin
      @(negedge clk);
      r = rdy[d];
      @(posedge clk);
      waited++;
    end while (!r && waited < 30);
    #1;
    dv[d] = 1'b0;
    check($sformatf("accept_d%0d_w%0h", d, w), 32'(r), 32'd1);
  endtask

  // ---------------- scoreboard ----------------
  task automatic drain(input int d, input string name);
    int         cyc;
    logic [4:0] e;
    cyc = 0;
    while (exp_q.size() > 0) begin
      tick();
      e = exp_q.pop_front();
      check($sformatf("%s_c%0d", name, cyc),
            32'({rdy[d], bsy[d], sv[d], so[d], sl[d]}), 32'(e));
      cyc++;
    end
  endtask

  task automatic run_stream(input int d, input string name, input int n,
                            input logic [3:0] w0, input logic [3:0] w1,
                            input logic [3:0] w2);
    fork
      begin
        send(d, w0);
        if (n > 1) send(d, w1);
        if (n > 2) send(d, w2);
      end
      drain(d, name);
    join
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation time limit");
  end

  initial begin
    for (int i = 0; i < 3; i++) begin
      din[i] = 4'd0;
      dv[i]  = 1'b0;
    end

    // Reset held from time 0.
    rst = 1'b1;
    #1;
    check("rst_in_ready", 32'(rdy[0]), 32'd0);
    check("rst_busy", 32'(bsy[0]), 32'd0);
    check("rst_ser_valid", 32'(sv[0]), 32'd0);
    check("rst_ser_out", 32'(so[0]), 32'd0);
    check("rst_state", 32'(st[0]), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rel_in_ready_a", 32'(rdy[0]), 32'd1);
    check("rel_in_ready_b", 32'(rdy[1]), 32'd1);
    check("rel_in_ready_c", 32'(rdy[2]), 32'd1);
    check("rel_busy", 32'(bsy[0]), 32'd0);
    tick();

    // Single word, MSB first, GAP=1: 1,0,0,1 then one gap cycle.
    exp_q = '{5'b01000, 5'b11110, 5'b11100, 5'b11100, 5'b11111,
              5'b11000, 5'b10000};
    run_stream(0, "single", 1, 4'b1001, 4'b0000, 4'b0000);

    // Back-to-back, GAP=1: gap, idle, then the second word.
    exp_q = '{5'b01000, 5'b11110, 5'b01100, 5'b01100, 5'b01111,
              5'b01000, 5'b01000, 5'b11100, 5'b11110, 5'b11110,
              5'b11101, 5'b11000, 5'b10000};
    run_stream(0, "b2b_gap1", 2, 4'b1001, 4'b0110, 4'b0000);

    // GAP=0 with a third word under backpressure: no bubble, nothing lost.
    exp_q = '{5'b01000, 5'b11110, 5'b01100, 5'b01100, 5'b01111,
              5'b11100, 5'b01110, 5'b01110, 5'b01101,
              5'b11110, 5'b11110, 5'b11100, 5'b11101, 5'b10000};
    run_stream(1, "bp_gap0", 3, 4'b1001, 4'b0110, 4'b1100);

    // LSB first: 1101 -> 1,0,1,1.
    exp_q = '{5'b01000, 5'b11110, 5'b11100, 5'b11110, 5'b11111,
              5'b11000, 5'b10000};
    run_stream(2, "lsb", 1, 4'b1101, 4'b0000, 4'b0000);

    // Reset in the middle of 1011, after two bits.
    fork
      send(0, 4'b1011);
      begin
        tick();
        tick();
        check("mid_bit0", 32'({sv[0], so[0]}), 32'b11);
        tick();
        check("mid_bit1", 32'({sv[0], so[0]}), 32'b10);
      end
    join
    #3;
    rst = 1'b1;
    #1;
    check("mid_rst_valid", 32'(sv[0]), 32'd0);
    check("mid_rst_out", 32'(so[0]), 32'd0);
    check("mid_rst_busy", 32'(bsy[0]), 32'd0);
    check("mid_rst_ready", 32'(rdy[0]), 32'd0);
    @(posedge clk);
    #3;
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("post_rst_quiet_%0d", i), 32'({sv[0], bsy[0], rdy[0]}), 32'b001);
    end

    exp_q = '{5'b01000, 5'b11100, 5'b11100, 5'b11100, 5'b11111,
              5'b11000, 5'b10000};
    run_stream(0, "post_rst_word", 1, 4'b0001, 4'b0000, 4'b0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
